// File: rtl/wb_port_arbiter_if.sv
// Bundle of the pipeline/MDU request side and the register-file write side of
// the writeback port arbiter.
interface wb_port_arbiter_if #(
   parameter int unsigned W      = 32,
   parameter int unsigned REG_AW = 5
);
   logic                  pipe_valid;
   logic [REG_AW-1:0]     pipe_rd;
   logic [W-1:0]          pipe_data;
   logic                  mdu_valid;
   logic                  mdu_ready;
   logic [REG_AW-1:0]     mdu_rd;
   logic [W-1:0]          mdu_data;
   logic                  rf_we;
   logic [REG_AW-1:0]     rf_waddr;
   logic [W-1:0]          rf_wdata;
   logic                  pipe_stall;
   logic [2**REG_AW-1:0]  pend_mask;
   logic                  proto_err;

   modport master (
      output pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
      input  mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_mask, proto_err
   );

   modport slave (
      input  pipe_valid, pipe_rd, pipe_data, mdu_valid, mdu_rd, mdu_data,
      output mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall, pend_mask, proto_err
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results
// queue in a small FIFO and get a forced one-cycle pipeline stall after MAX_WAIT denials.
module wb_port_arbiter #(
   parameter int unsigned W        = 32,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   wb_port_arbiter_if.slave   bus
);
   localparam int unsigned NREG = 1 << REG_AW;
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned WCW  = $clog2(MAX_WAIT + 1);

   localparam logic [0:0] StNormal = 1'b0;
   localparam logic [0:0] StForce  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [WCW-1:0]    wait_q, wait_d;
   logic [CW-1:0]     count_q, count_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [REG_AW-1:0] mem_rd_q [DEPTH];
   logic [REG_AW-1:0] mem_rd_d [DEPTH];
   logic [W-1:0]      mem_data_q [DEPTH];
   logic [W-1:0]      mem_data_d [DEPTH];
   logic              rf_we_q, rf_we_d;
   logic              rf_mdu_q, rf_mdu_d;
   logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
   logic [W-1:0]      rf_wdata_q, rf_wdata_d;
   logic              proto_err_q, proto_err_d;

   logic              empty, full, pipe_req, enq, deq, head_denied;
   logic              pipe_grant, head_grant;
   logic [AW-1:0]     offs;
   logic [NREG-1:0]   pend_mask;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign pipe_req = bus.pipe_valid && (bus.pipe_rd != '0);
   // rd==0 results still complete the handshake but never occupy a slot.
   assign enq      = bus.mdu_valid && !full && (bus.mdu_rd != '0);

   always_comb begin
      pipe_grant = 1'b0;
      head_grant = 1'b0;
      if (state_q == StForce) begin
         head_grant = !empty;
      end else if (pipe_req) begin
         pipe_grant = 1'b1;
      end else begin
         head_grant = !empty;
      end
   end

   assign deq         = head_grant;
   assign head_denied = !empty && !head_grant;

   always_comb begin
      mem_rd_d    = mem_rd_q;
      mem_data_d  = mem_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rf_we_d     = pipe_grant || head_grant;
      rf_mdu_d    = head_grant;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      proto_err_d = proto_err_q || ((state_q == StForce) && pipe_req);
      wait_d      = head_denied ? wait_q + 1'b1 : '0;
      state_d     = StNormal;

      if (enq) begin
         mem_rd_d[wr_ptr_q]   = bus.mdu_rd;
         mem_data_d[wr_ptr_q] = bus.mdu_data;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (pipe_grant) begin
         rf_waddr_d = bus.pipe_rd;
         rf_wdata_d = bus.pipe_data;
      end else if (head_grant) begin
         rf_waddr_d = mem_rd_q[rd_ptr_q];
         rf_wdata_d = mem_data_q[rd_ptr_q];
      end

      // FORCE always lasts exactly one cycle; the head is granted there.
      if ((state_q == StNormal) && head_denied && (wait_q == WCW'(MAX_WAIT - 1))) begin
         state_d = StForce;
      end
   end

   always_comb begin
      pend_mask = '0;
      offs      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = AW'(i) - rd_ptr_q;
         if (CW'(offs) < count_q) begin
            pend_mask[mem_rd_q[i]] = 1'b1;
         end
      end
      if (rf_we_q && rf_mdu_q) begin
         pend_mask[rf_waddr_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StNormal;
         wait_q      <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         rf_we_q     <= 1'b0;
         rf_mdu_q    <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         proto_err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_rd_q[i]   <= '0;
            mem_data_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rf_we_q     <= rf_we_d;
         rf_mdu_q    <= rf_mdu_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
         proto_err_q <= proto_err_d;
         mem_rd_q    <= mem_rd_d;
         mem_data_q  <= mem_data_d;
      end
   end

   assign bus.mdu_ready  = !full && !rst;
   assign bus.rf_we      = rf_we_q;
   assign bus.rf_waddr   = rf_waddr_q;
   assign bus.rf_wdata   = rf_wdata_q;
   assign bus.pipe_stall = (state_q == StForce);
   assign bus.pend_mask  = pend_mask;
   assign bus.proto_err  = proto_err_q;
endmodule
